// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake from a
// variable-latency instruction memory, and presents one instruction at a time to IF/ID.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] inst_mem_out,
   output logic        if_valid
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      READY   = 2'd1,
      DISCARD = 2'd2
   } fetchState_t;

   fetchState_t r_state;
   logic [31:0] r_pcReg;
   logic [31:0] r_instBuf;
   logic [31:0] r_pcBuf;
   logic [31:0] r_reqAddr;
   logic [31:0] w_pcNext;

   assign w_pcNext = r_pcReg + PC_INC;

   // A branch always wins; while DISCARD drains the stale fetch, r_reqAddr keeps the
   // memory address stable even though r_pcReg already points at the branch target.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= FETCH;
         r_pcReg   <= RESET_PC;
         r_instBuf <= '0;
         r_pcBuf   <= '0;
         r_reqAddr <= '0;
      end else begin
         case (r_state)
            FETCH: begin
               if (branch_taken) begin
                  r_pcReg <= branch_addr;
                  if (!imem_ack) begin
                     r_state   <= DISCARD;
                     r_reqAddr <= r_pcReg;
                  end
               end else if (imem_ack) begin
                  r_instBuf <= imem_rdata;
                  r_pcBuf   <= w_pcNext;
                  r_pcReg   <= w_pcNext;
                  r_state   <= READY;
               end
            end
            READY: begin
               if (branch_taken) begin
                  r_pcReg <= branch_addr;
                  r_state <= FETCH;
               end else if (!freeze) begin
                  r_state <= FETCH;
               end
            end
            DISCARD: begin
               if (branch_taken) begin
                  r_pcReg <= branch_addr;
               end else if (imem_ack) begin
                  r_state <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

   // Invalid cycles present all zeros, which decode treats as a NOP bubble.
   assign imem_req     = rst & (r_state != READY);
   assign imem_addr    = (r_state == DISCARD) ? r_reqAddr : r_pcReg;
   assign if_valid     = (r_state == READY);
   assign PC           = if_valid ? r_pcBuf : '0;
   assign inst_mem_out = if_valid ? r_instBuf : '0;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a scoreboard queue holds every instruction
// the memory hands over, and a negedge monitor compares each new presentation against it.
module tb_if_fetch_stage;

   localparam logic [31:0] PC_INC = 32'd4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } sbEntry_t;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branchTaken;
   logic [31:0] branchAddr;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemRdata;
   logic [31:0] pcOut;
   logic [31:0] instOut;
   logic        ifValid;

   sbEntry_t sbQ[$];
   int checkCount = 0;
   int failCount  = 0;
   logic prevValid = 1'b0;

   if_fetch_stage #(.RESET_PC(32'h0000_0000), .PC_INC(PC_INC)) dut (
      .clk         (clk),
      .rst         (rst),
      .freeze      (freeze),
      .branch_taken(branchTaken),
      .branch_addr (branchAddr),
      .imem_req    (imemReq),
      .imem_addr   (imemAddr),
      .imem_ack    (imemAck),
      .imem_rdata  (imemRdata),
      .PC          (pcOut),
      .inst_mem_out(instOut),
      .if_valid    (ifValid)
   );

   // Free-running 10ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] memData(input logic [31:0] addr);
      return addr ^ 32'hE59F_0000;
   endfunction

   // Each fresh presentation must match the oldest accepted fetch.
   always @(negedge clk) begin
      if (rst && ifValid && !prevValid) begin
         if (sbQ.size() == 0) begin
            checkOutput("spuriousPresent", {31'd0, ifValid}, 32'd0);
         end else begin
            sbEntry_t e;
            e = sbQ.pop_front();
            checkOutput("presentPc", pcOut, e.pc);
            checkOutput("presentInst", instOut, e.inst);
         end
      end
      prevValid = ifValid;
   end

   // Hold the request for lat cycles, then complete it and record the expected result.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input int lat);
      for (int i = 0; i < lat; i++) begin
         checkOutput("waitReq", {31'd0, imemReq}, 32'd1);
         checkOutput("waitAddr", imemAddr, addr);
         checkOutput("waitValid", {31'd0, ifValid}, 32'd0);
         checkOutput("waitPc", pcOut, 32'd0);
         checkOutput("waitInst", instOut, 32'd0);
         imemAck = 1'b0;
         tick();
      end
      checkOutput("req", {31'd0, imemReq}, 32'd1);
      checkOutput("addr", imemAddr, addr);
      imemAck   = 1'b1;
      imemRdata = data;
      sbQ.push_back('{pc: addr + PC_INC, inst: data});
      tick();
      imemAck   = 1'b0;
      imemRdata = $urandom;
   endtask

   task automatic releaseReady();
      checkOutput("readyValid", {31'd0, ifValid}, 32'd1);
      checkOutput("readyReq", {31'd0, imemReq}, 32'd0);
      freeze = 1'b0;
      tick();
   endtask

   initial begin
      rst         = 1'b0;
      freeze      = 1'b0;
      branchTaken = 1'b0;
      branchAddr  = '0;
      imemAck     = 1'b0;
      imemRdata   = '0;

      // Reset state
      tick();
      tick();
      checkOutput("rstReq", {31'd0, imemReq}, 32'd0);
      checkOutput("rstValid", {31'd0, ifValid}, 32'd0);
      checkOutput("rstPc", pcOut, 32'd0);
      checkOutput("rstInst", instOut, 32'd0);
      rst = 1'b1;
      tick();

      // Back-to-back single-cycle acks
      for (int i = 0; i < 4; i++) begin
         applyStimulus(32'(i * 4), memData(32'(i * 4)), 0);
         releaseReady();
      end

      // Three-cycle memory latency at 0x10
      applyStimulus(32'h10, memData(32'h10), 3);
      releaseReady();

      // Freeze holds the presented instruction
      applyStimulus(32'h14, 32'hE3A0_1005, 0);
      freeze = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkOutput("frzValid", {31'd0, ifValid}, 32'd1);
         checkOutput("frzPc", pcOut, 32'h18);
         checkOutput("frzInst", instOut, 32'hE3A0_1005);
         checkOutput("frzReq", {31'd0, imemReq}, 32'd0);
         tick();
      end
      releaseReady();
      checkOutput("postFrzAddr", imemAddr, 32'h18);

      applyStimulus(32'h18, memData(32'h18), 1);
      releaseReady();
      applyStimulus(32'h1C, memData(32'h1C), 0);
      releaseReady();

      // Branch while 0x20 is outstanding: old address held, data dropped
      checkOutput("brWaitAddr", imemAddr, 32'h20);
      tick();
      branchTaken = 1'b1;
      branchAddr  = 32'h100;
      tick();
      branchTaken = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checkOutput("discReq", {31'd0, imemReq}, 32'd1);
         checkOutput("discAddr", imemAddr, 32'h20);
         checkOutput("discValid", {31'd0, ifValid}, 32'd0);
         tick();
      end
      imemAck   = 1'b1;
      imemRdata = 32'hDEAD_BEEF;
      tick();
      imemAck   = 1'b0;
      applyStimulus(32'h100, memData(32'h100), 0);
      releaseReady();

      // Branch coinciding with ack in FETCH drops the returned word
      checkOutput("brAckAddr", imemAddr, 32'h104);
      branchTaken = 1'b1;
      branchAddr  = 32'h200;
      imemAck     = 1'b1;
      imemRdata   = 32'hBAD0_0104;
      tick();
      branchTaken = 1'b0;
      imemAck     = 1'b0;
      checkOutput("brAckValid", {31'd0, ifValid}, 32'd0);
      applyStimulus(32'h200, memData(32'h200), 1);

      // Branch overrides freeze in READY
      freeze      = 1'b1;
      branchTaken = 1'b1;
      branchAddr  = 32'h300;
      tick();
      branchTaken = 1'b0;
      freeze      = 1'b0;
      checkOutput("brFrzValid", {31'd0, ifValid}, 32'd0);
      checkOutput("brFrzPc", pcOut, 32'd0);
      checkOutput("brFrzInst", instOut, 32'd0);
      applyStimulus(32'h300, memData(32'h300), 0);
      releaseReady();

      // Two branches during DISCARD; the last target wins, then PC wraps past 2^32
      branchTaken = 1'b1;
      branchAddr  = 32'h400;
      tick();
      branchAddr  = 32'hFFFF_FFFC;
      tick();
      branchTaken = 1'b0;
      checkOutput("disc2Addr", imemAddr, 32'h304);
      imemAck = 1'b1;
      tick();
      imemAck = 1'b0;
      applyStimulus(32'hFFFF_FFFC, memData(32'hFFFF_FFFC), 0);
      releaseReady();
      applyStimulus(32'h0, memData(32'h0), 0);
      releaseReady();

      // Reset during an outstanding fetch at 0x4, with a stray ack while in reset
      checkOutput("preRstAddr", imemAddr, 32'h4);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("midRstReq", {31'd0, imemReq}, 32'd0);
      checkOutput("midRstValid", {31'd0, ifValid}, 32'd0);
      imemAck = 1'b1;
      tick();
      tick();
      imemAck = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("postRstValid", {31'd0, ifValid}, 32'd0);
      applyStimulus(32'h0, memData(32'h0), 1);
      releaseReady();

      tick();
      checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
